// File: rtl/conv_pool_channels_seq_if.sv
// Window-in / pixel-out handshake bundle for conv_pool_channels_seq.
// The master modport is the upstream/downstream side; the slave modport is the block itself.
interface conv_pool_channels_seq_if #(
    parameter int CHAN_IN  = 5,
    parameter int CHAN_OUT = 18,
    parameter int K        = 5,
    parameter int BW       = 7
);
    localparam int W = K + 1;

    logic                            in_valid;
    logic                            in_ready;
    logic [CHAN_IN*W*W-1:0]          window;
    logic [CHAN_OUT*CHAN_IN*K*K-1:0] kernels;
    logic [CHAN_OUT*BW-1:0]          offset;
    logic                            out_valid;
    logic                            out_ready;
    logic [CHAN_OUT-1:0]             pixel;

    modport master (
        output in_valid, window, kernels, offset, out_ready,
        input  in_ready, out_valid, pixel
    );

    modport slave (
        input  in_valid, window, kernels, offset, out_ready,
        output in_ready, out_valid, pixel
    );
endinterface

// File: rtl/conv_pool_channels_seq.sv
// Binary XNOR-popcount conv + 2x2 max-pool + threshold, LANES outputs per cycle over GROUPS cycles.
// Latency: out_valid GROUPS+1 cycles after accept; DONE holds under backpressure. Optional CONV_POOL_PERF_CNT_EN adds win_count.
module conv_pool_channels_seq #(
    parameter int CHAN_IN  = 5,
    parameter int CHAN_OUT = 18,
    parameter int K        = 5,
    parameter int LANES    = 6,
    parameter int BW       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef CONV_POOL_PERF_CNT_EN
    output logic [15:0] win_count,
`endif
    conv_pool_channels_seq_if.slave bus
);
    localparam int W      = K + 1;
    localparam int KB     = CHAN_IN * K * K;
    localparam int WB     = CHAN_IN * W * W;
    localparam int GROUPS = (CHAN_OUT + LANES - 1) / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t              state_q;
    logic [GW-1:0]       g_q;
    logic [GW-1:0]       g_d;
    logic [WB-1:0]       win_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [CHAN_OUT-1:0] pixel_q;

    logic [KB-1:0]       ker_sel [LANES];
    logic [BW-1:0]       off_sel [LANES];
    logic [LANES-1:0]    lane_hit;

    // Clamp keeps dead out-of-range lanes from elaborating illegal selects.
    function automatic int oidx(input int g, input int l);
        return (g * LANES + l < CHAN_OUT) ? g * LANES + l : 0;
    endfunction

    assign g_d = g_q + GW'(1);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            ker_sel[l] = '0;
            off_sel[l] = '0;
            for (int g = 0; g < GROUPS; g++) begin
                if ((g * LANES + l < CHAN_OUT) && (g_q == GW'(g))) begin
                    ker_sel[l] = bus.kernels[oidx(g, l)*KB +: KB];
                    off_sel[l] = bus.offset[oidx(g, l)*BW +: BW];
                end
            end
        end
    end

    always_comb begin : lane_eval
        logic [BW-1:0] pop;
        logic [BW-1:0] best;
        logic          mbit;
        pop      = '0;
        best     = '0;
        mbit     = 1'b0;
        lane_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            best = '0;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    pop = '0;
                    for (int c = 0; c < CHAN_IN; c++) begin
                        for (int r = 0; r < K; r++) begin
                            for (int col = 0; col < K; col++) begin
                                mbit = win_q[(c*W + r + dr)*W + col + dc] ~^ ker_sel[l][(c*K + r)*K + col];
                                pop  = pop + {{(BW-1){1'b0}}, mbit};
                            end
                        end
                    end
                    if (pop > best) best = pop;
                end
            end
            lane_hit[l] = (best >= off_sel[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            win_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pixel_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        win_q      <= bus.window;
                        g_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int g = 0; g < GROUPS; g++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if ((g * LANES + l < CHAN_OUT) && (g_q == GW'(g)))
                                pixel_q[oidx(g, l)] <= lane_hit[l];
                        end
                    end
                    if (g_q == GW'(GROUPS - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        g_q <= g_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pixel     = pixel_q;

`ifdef CONV_POOL_PERF_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = (out_valid_q && bus.out_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign win_count = cnt_q;
`endif
endmodule

// File: tb/tb_conv_pool_channels_seq.sv
module tb_conv_pool_channels_seq;
    localparam int CI = 5, CO = 18, K = 5, LANES = 6, BW = 7;
    localparam int W = K + 1;
    localparam int GROUPS = (CO + LANES - 1) / LANES;
    localparam int WB = CI * W * W;
    localparam int KB = CO * CI * K * K;
    localparam int OB = CO * BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_pool_channels_seq_if #(.CHAN_IN(CI), .CHAN_OUT(CO), .K(K), .BW(BW)) bus_if ();

`ifdef CONV_POOL_PERF_CNT_EN
    logic [15:0] win_count;
`endif

    conv_pool_channels_seq #(.CHAN_IN(CI), .CHAN_OUT(CO), .K(K), .LANES(LANES), .BW(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CONV_POOL_PERF_CNT_EN
        .win_count(win_count),
`endif
        .bus      (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count matching bits per pool position, take the best, compare to offset.
    function automatic logic [CO-1:0] ref_pixel(input logic [WB-1:0] w, input logic [KB-1:0] k,
                                                 input logic [OB-1:0] off);
        logic [CO-1:0] res;
        int best, cnt;
        res = '0;
        for (int o = 0; o < CO; o++) begin
            best = 0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    cnt = 0;
                    for (int c = 0; c < CI; c++)
                        for (int r = 0; r < K; r++)
                            for (int col = 0; col < K; col++)
                                if (w[(c*W + r + dr)*W + col + dc] == k[((o*CI + c)*K + r)*K + col]) cnt++;
                    if (cnt > best) best = cnt;
                end
            res[o] = (best >= int'(off[o*BW +: BW]));
        end
        return res;
    endfunction

    task automatic run_txn(input logic [WB-1:0] w, input logic [KB-1:0] k, input logic [OB-1:0] off,
                           input int hold, input string tag, output logic [CO-1:0] seen);
        logic [CO-1:0] exp;
        int n;
        seen = '0;
        exp = ref_pixel(w, k, off);
        @(negedge clk);
        bus_if.window    = w;
        bus_if.kernels   = k;
        bus_if.offset    = off;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        n = 0;
        while (!bus_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready) begin
            chk({tag, "_accept_timeout"}, 64'(bus_if.in_ready), 64'd1);
            bus_if.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.window   = ~w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.out_valid && n < 50);
        chk({tag, "_latency"}, 64'(n), 64'(GROUPS + 1));
        chk({tag, "_pixel"}, 64'(bus_if.pixel), 64'(exp));
        seen = bus_if.pixel;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_bp_valid"}, 64'(bus_if.out_valid), 64'd1);
            chk({tag, "_bp_pixel"}, 64'(bus_if.pixel), 64'(exp));
            chk({tag, "_bp_in_ready"}, 64'(bus_if.in_ready), 64'd0);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        chk({tag, "_post_valid"}, 64'(bus_if.out_valid), 64'd0);
        chk({tag, "_post_in_ready"}, 64'(bus_if.in_ready), 64'd1);
        chk({tag, "_post_pixel"}, 64'(bus_if.pixel), 64'(exp));
    endtask

    function automatic logic [OB-1:0] const_off(input int v);
        logic [OB-1:0] r;
        for (int o = 0; o < CO; o++) r[o*BW +: BW] = BW'(v);
        return r;
    endfunction

    logic [WB-1:0]  w;
    logic [KB-1:0]  kk;
    logic [OB-1:0]  off;
    logic [CO-1:0]  seen;
    int             n;
    logic           saw_valid;

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.window    = '0;
        bus_if.kernels   = '0;
        bus_if.offset    = '0;
        #12;
        chk("reset_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("reset_pixel", 64'(bus_if.pixel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn('0, '0, const_off(125), 0, "zeros", seen);
        chk("zeros_literal", 64'(seen), 64'h3FFFF);

        kk = '1;
        for (int o = 0; o < CO; o++) off[o*BW +: BW] = BW'(o % 2);
        run_txn('0, kk, off, 0, "parity", seen);
        chk("parity_literal", 64'(seen), 64'h15555);

        w = '0;
        for (int c = 0; c < CI; c++)
            for (int col = 0; col < W; col++) w[(c*W)*W + col] = 1'b1;
        run_txn(w, '0, const_off(125), 0, "row0_125", seen);
        chk("row0_125_literal", 64'(seen), 64'h3FFFF);
        run_txn(w, '0, const_off(126), 0, "row0_126", seen);
        chk("row0_126_literal", 64'(seen), 64'h0);

        run_txn('0, '0, const_off(125), 10, "backpressure", seen);

        // Reset while the second group is being evaluated.
        @(negedge clk);
        bus_if.window   = '0;
        bus_if.kernels  = '0;
        bus_if.offset   = const_off(125);
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("midrst_pixel", 64'(bus_if.pixel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) saw_valid = 1'b1;
        end
        chk("midrst_no_valid", 64'(saw_valid), 64'd0);
        chk("midrst_pixel_after", 64'(bus_if.pixel), 64'd0);
        run_txn('0, '0, const_off(125), 0, "after_rst", seen);
        chk("after_rst_literal", 64'(seen), 64'h3FFFF);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < WB; i++) w[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < KB; i++) kk[i] = 1'($urandom_range(0, 1));
            for (int o = 0; o < CO; o++) off[o*BW +: BW] = BW'($urandom_range(58, 82));
            run_txn(w, kk, off, int'($urandom_range(0, 3)), $sformatf("rand%0d", t), seen);
        end

`ifdef CONV_POOL_PERF_CNT_EN
        chk("win_count", 64'(win_count), 64'(exp_cnt));
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        run_txn('0, '0, const_off(125), 0, "sat1", seen);
        run_txn('0, '0, const_off(125), 0, "sat2", seen);
        chk("win_count_sat", 64'(win_count), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_pool_channels_seq.md
Name: conv_pool_channels_seq

Overview:
Time-multiplexed, parametrised binary (XNOR-popcount) convolution, 2x2 max-pool and threshold block.
- Accepts one (K+1)x(K+1) binary input window per transaction, for each of CHAN_IN channels.
- Produces CHAN_OUT thresholded output bits.
- Evaluates LANES output channels per cycle, so arbitrary CHAN_OUT is handled with bounded logic.
- Sits between the window line-buffer and the next layer's input packer; valid/ready handshake on both sides.

Parameters:
CHAN_IN, 5, input channels per window
CHAN_OUT, 18, output channels (thresholded pixels)
K, 5, square kernel size; window is W=K+1 per side
LANES, 6, output channels computed per cycle; GROUPS=ceil(CHAN_OUT/LANES)
BW, 7, offset/popcount width; must be >= $clog2(CHAN_IN*K*K+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  window valid
in_ready  out  1  block can accept a window
window  in  CHAN_IN*W*W  binary window; bit ((c*W+r)*W+col)
kernels  in  CHAN_OUT*CHAN_IN*K*K  weights; bit (((o*CHAN_IN+c)*K+r)*K+col)
offset  in  CHAN_OUT*BW  per-output threshold, unsigned; field o at [o*BW +: BW]
out_valid  out  1  pixel vector valid
out_ready  in  1  downstream accepts
pixel  out  CHAN_OUT  thresholded pooled outputs, bit o = channel o

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, pixel=0, group counter=0, window register=0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register window, clear group counter g=0, go to COMPUTE.
- COMPUTE (in_ready=0, one group per cycle), for lane l, channel o=g*LANES+l:
  - For each pool position (dr,dc) in {0,1}^2: pop(dr,dc) = sum over c,r,col of XNOR(win[c][r+dr][col+dc], ker[o][c][r][col]).
  - m = max of the 4 pops. Widths: pop is BW bits, sum cannot overflow given the BW rule.
  - pixel[o] <= (m >= offset[o]), unsigned compare.
  - Lanes with o >= CHAN_OUT are ignored; the pixel register is never written out of range.
  - g increments each cycle; after g=GROUPS-1, go to DONE.
- DONE:
  - out_valid=1; pixel stable until handshake.
  - On out_ready, go to IDLE; out_valid falls next cycle.
  - No same-cycle re-accept: in_ready rises the cycle after the output handshake.
- Latency: accept at cycle 0; out_valid asserted at cycle GROUPS+1 (default 4). Throughput is one window per GROUPS+2 cycles with out_ready held high.
- kernels and offset are sampled live during COMPUTE. They must be stable from accept through the last COMPUTE cycle; window is registered and may change after accept.
- Backpressure: DONE holds indefinitely; pixel and out_valid do not change while out_ready=0.
- in_valid during COMPUTE/DONE is ignored (in_ready=0); the upstream holds it.
- Reset mid-COMPUTE or mid-DONE: immediate return to the reset state; the partial result is discarded and out_valid is not asserted for it.
- pixel keeps its last value in IDLE until overwritten by the next COMPUTE.

Optional Feature:
Macro CONV_POOL_PERF_CNT_EN.
- Defined: adds output port win_count [15:0].
  - Increments on each output handshake (out_valid&&out_ready) and saturates at 16'hFFFF.
  - Cleared by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Window all 0, kernels all 0, offsets all 125 (defaults) -> each pop=125, pixel=18'h3FFFF, out_valid at cycle 4 after accept.
- Window all 0, kernels all 1; offset[o]=0 for even o, 1 for odd o -> pop=0, pixel bits even=1, odd=0 (18'h15555).
- Window row 0 all 1 else 0, kernels all 0, offset=125 -> pool position dr=1 gives 125, so max=125, pixel all 1; offset=126 -> pixel all 0.
- out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, pixel constant, in_ready=0; release -> in_ready=1 one cycle after the handshake.
- Assert rst_n=0 during COMPUTE at g=1 -> out_valid=0, in_ready=1, pixel=0 after release; the next window completes normally with correct result.
- With CONV_POOL_PERF_CNT_EN, 3 back-to-back transactions -> win_count=3; preload near 16'hFFFF via force -> holds at 16'hFFFF.
